// File: rtl/carry_increment_pipe.sv
// Pipelined carry-increment adder/subtractor: one BLOCK-bit slice resolved per stage,
// inter-slice carry registered, valid/ready handshake with a single global advance.
module carry_increment_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTAGE = WIDTH / BLOCK;

    if (BLOCK < 1 || NSTAGE < 1 || (WIDTH % BLOCK) != 0) begin : g_param_check
        $error("carry_increment_pipe: WIDTH must be a non-zero multiple of BLOCK");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;

    assign b_eff    = sub ? ~b : b;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    genvar gi;
    for (gi = 0; gi < NSTAGE; gi++) begin : gen_stage
        logic [BLOCK-1:0]         sa;
        logic [BLOCK-1:0]         sb;
        logic                     c_in;
        logic                     v_in;
        logic [BLOCK:0]           raw;
        logic [BLOCK:0]           inc;
        logic [BLOCK:0]           sel;
        logic [(gi+1)*BLOCK-1:0]  sum_next;
        logic                     valid_reg;
        logic                     carry_reg;
        logic [(gi+1)*BLOCK-1:0]  sum_reg;

        if (gi == 0) begin : g_src
            assign sa       = a[BLOCK-1:0];
            assign sb       = b_eff[BLOCK-1:0];
            assign c_in     = sub | cin;
            assign v_in     = in_valid;
            assign sum_next = sel[BLOCK-1:0];
        end else begin : g_src
            assign sa       = gen_stage[gi-1].g_fwd.a_rem_reg[BLOCK-1:0];
            assign sb       = gen_stage[gi-1].g_fwd.b_rem_reg[BLOCK-1:0];
            assign c_in     = gen_stage[gi-1].carry_reg;
            assign v_in     = gen_stage[gi-1].valid_reg;
            assign sum_next = {sel[BLOCK-1:0], gen_stage[gi-1].sum_reg};
        end

        // Both candidate slice sums are formed up front; the incoming carry only selects.
        assign raw = {1'b0, sa} + {1'b0, sb};
        assign inc = raw + {{BLOCK{1'b0}}, 1'b1};
        assign sel = c_in ? inc : raw;

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg <= 1'b0;
                carry_reg <= 1'b0;
                sum_reg   <= '0;
            end else if (adv) begin
                valid_reg <= v_in;
                carry_reg <= sel[BLOCK];
                sum_reg   <= sum_next;
            end
        end

        // Operand slices not yet consumed ride along with the op, shifted down one slice per stage.
        if (gi < NSTAGE - 1) begin : g_fwd
            logic [WIDTH-(gi+1)*BLOCK-1:0] a_rem_next;
            logic [WIDTH-(gi+1)*BLOCK-1:0] b_rem_next;
            logic [WIDTH-(gi+1)*BLOCK-1:0] a_rem_reg;
            logic [WIDTH-(gi+1)*BLOCK-1:0] b_rem_reg;

            if (gi == 0) begin : g_first
                assign a_rem_next = a[WIDTH-1:BLOCK];
                assign b_rem_next = b_eff[WIDTH-1:BLOCK];
            end else begin : g_next
                assign a_rem_next = gen_stage[gi-1].g_fwd.a_rem_reg[WIDTH-gi*BLOCK-1:BLOCK];
                assign b_rem_next = gen_stage[gi-1].g_fwd.b_rem_reg[WIDTH-gi*BLOCK-1:BLOCK];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_rem_reg <= '0;
                    b_rem_reg <= '0;
                end else if (adv) begin
                    a_rem_reg <= a_rem_next;
                    b_rem_reg <= b_rem_next;
                end
            end
        end

        if (gi == NSTAGE - 1) begin : g_last
            logic msb_carry;
            logic ovf_reg;

            // Carry into the top bit recovered from the slice sum and its operand bits.
            assign msb_carry = sel[BLOCK-1] ^ sa[BLOCK-1] ^ sb[BLOCK-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_reg <= 1'b0;
                end else if (adv) begin
                    ovf_reg <= msb_carry ^ sel[BLOCK];
                end
            end
        end
    end

    assign out_valid = gen_stage[NSTAGE-1].valid_reg;
    assign sum       = gen_stage[NSTAGE-1].sum_reg;
    assign cout      = gen_stage[NSTAGE-1].carry_reg;
    assign ovf       = gen_stage[NSTAGE-1].g_last.ovf_reg;

endmodule

// File: tb/tb_carry_increment_pipe.sv
// Self-checking bench for carry_increment_pipe: directed corner cases plus randomized
// traffic scored against a plain-arithmetic model queue.
module tb_carry_increment_pipe;

    localparam int WIDTH = 32;
    localparam int BLOCK = 8;
    localparam int LAT   = WIDTH / BLOCK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    carry_increment_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    logic [WIDTH+1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result = {ovf, cout, sum} from plain integer arithmetic and sign rules.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                              input logic mcin, input logic msub);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   t;
        logic             o;
        bb = msub ? ~mb : mb;
        t  = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, (msub ? 1'b1 : mcin)};
        o  = (ma[WIDTH-1] == bb[WIDTH-1]) && (t[WIDTH-1] != ma[WIDTH-1]);
        return {o, t[WIDTH], t[WIDTH-1:0]};
    endfunction

    // Compare process: sampled on the falling edge, mid-cycle.
    logic             hold_prev = 1'b0;
    logic [WIDTH+1:0] held;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            check("in_ready_eq_adv", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
            if (hold_prev) begin
                check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
                check("stall_hold_data", {30'd0, ovf, cout, sum}, {30'd0, held});
            end
            hold_prev = out_valid && !out_ready;
            held      = {ovf, cout, sum};
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got %0h expected none", sum);
                end else begin
                    check("result", {30'd0, ovf, cout, sum}, {30'd0, exp_q.pop_front()});
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic run_one(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                           input logic tcin, input logic tsub, input logic [WIDTH-1:0] esum,
                           input logic ecout, input logic eovf);
        int cyc;
        @(posedge clk); #1;
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'(LAT));
        check({name, "_sum"}, {32'd0, sum}, {32'd0, esum});
        check({name, "_cout"}, {63'd0, cout}, {63'd0, ecout});
        check({name, "_ovf"}, {63'd0, ovf}, {63'd0, eovf});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int base;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_sum", {32'd0, sum}, 64'd0);
        check("reset_cout", {63'd0, cout}, 64'd0);
        check("reset_ovf", {63'd0, ovf}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);

        run_one("add_basic", 32'h001F001F, 32'h0018000C, 1'b0, 1'b0, 32'h0037002B, 1'b0, 1'b0);
        run_one("wrap_cin1", 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_one("wrap_cin0", 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_one("add_ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_one("sub_neg", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_one("sub_ovf", 32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

        // Back-to-back random ops with a randomly stalling consumer.
        base = n_out;
        for (int i = 0; i < 16; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            guard = 0;
            forever begin
                out_ready = 1'($urandom);
                #1;
                if (in_ready || guard > 200) break;
                @(posedge clk); #1;
                guard++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 300) begin
            out_ready = 1'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        check("random_drained", 64'(exp_q.size()), 64'd0);
        check("random_count", 64'(n_out - base), 64'd16);

        // Reset with three ops in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("midrst_no_stale", {63'd0, out_valid}, 64'd0);
        end
        check("midrst_no_output", 64'(n_out - base), 64'd0);
        run_one("after_rst", 32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
